// File: rtl/kb_color_mapper.sv
// PS/2 scancode to RGB colour mapper with a programmable palette.
// Decodes make/break/extended prefixes and drives a registered colour to the VGA path.
module kb_color_mapper #(
    parameter int                         CHANNEL_W   = 3,
    parameter int                         NUM_KEYS    = 4,
    parameter int                         STICKY      = 0,
    parameter logic [3*CHANNEL_W-1:0]     DEFAULT_RGB = 9'b010_100_110
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             kb_code,
    input  logic                   kb_valid,
    input  logic                   wr_en,
    input  logic [3:0]             wr_idx,
    input  logic [7:0]             wr_key,
    input  logic [3*CHANNEL_W-1:0] wr_rgb,
    output logic [CHANNEL_W-1:0]   ored,
    output logic [CHANNEL_W-1:0]   ogreen,
    output logic [CHANNEL_W-1:0]   oblue,
    output logic                   key_down
);

    localparam int         RGB_W      = 3 * CHANNEL_W;
    localparam int         IDX_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam logic [4:0] NUM_KEYS_L = 5'(NUM_KEYS);

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t state, next_state;

    logic [7:0]       key_tab [NUM_KEYS];
    logic [RGB_W-1:0] rgb_tab [NUM_KEYS];

    logic             do_make;
    logic             do_break;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;

    logic             held_valid;
    logic             has_sel;
    logic [IDX_W-1:0] held_idx;
    logic             held_ok;
    logic             sel_active;
    logic [RGB_W-1:0] rgb_q;

    function automatic logic key_ok(input logic [7:0] k);
        return (k != 8'h00) && (k != 8'hE0) && (k != 8'hF0);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (i == 0) begin
                    key_tab[i] <= 8'h1C;
                    rgb_tab[i] <= {{CHANNEL_W{1'b1}}, {(2*CHANNEL_W){1'b0}}};
                end else if (i == 1) begin
                    key_tab[i] <= 8'h32;
                    rgb_tab[i] <= {{(2*CHANNEL_W){1'b0}}, {CHANNEL_W{1'b1}}};
                end else begin
                    key_tab[i] <= 8'h00;
                    rgb_tab[i] <= '0;
                end
            end
        end else if (wr_en && ({1'b0, wr_idx} < NUM_KEYS_L)) begin
            key_tab[wr_idx[IDX_W-1:0]] <= wr_key;
            rgb_tab[wr_idx[IDX_W-1:0]] <= wr_rgb;
        end
    end

    // Descending scan so the lowest-index valid entry wins; reads the pre-write palette.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_ok(key_tab[i]) && (key_tab[i] == kb_code)) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        do_make    = 1'b0;
        do_break   = 1'b0;
        if (kb_valid) begin
            case (state)
                IDLE: begin
                    if (kb_code == 8'hE0)      next_state = EXT;
                    else if (kb_code == 8'hF0) next_state = BREAK;
                    else                       do_make    = 1'b1;
                end
                BREAK: begin
                    if (kb_code == 8'hF0)      next_state = BREAK;
                    else if (kb_code == 8'hE0) next_state = EXT_BREAK;
                    else begin
                        do_break   = 1'b1;
                        next_state = IDLE;
                    end
                end
                EXT: begin
                    if (kb_code == 8'hF0) next_state = EXT_BREAK;
                    else                  next_state = IDLE;
                end
                EXT_BREAK: begin
                    if ((kb_code == 8'hE0) || (kb_code == 8'hF0)) next_state = EXT_BREAK;
                    else                                          next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign held_ok    = key_ok(key_tab[held_idx]);
    assign sel_active = (held_valid || ((STICKY != 0) && has_sel)) && held_ok;

    // A selection whose entry has been invalidated by a palette write is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_valid <= 1'b0;
            has_sel    <= 1'b0;
            held_idx   <= '0;
        end else begin
            if (!held_ok) begin
                held_valid <= 1'b0;
                has_sel    <= 1'b0;
            end
            if (do_make && match_hit) begin
                held_valid <= 1'b1;
                has_sel    <= 1'b1;
                held_idx   <= match_idx;
            end else if (do_break && match_hit && held_valid && (match_idx == held_idx)) begin
                held_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q    <= DEFAULT_RGB;
            key_down <= 1'b0;
        end else begin
            rgb_q    <= sel_active ? rgb_tab[held_idx] : DEFAULT_RGB;
            key_down <= held_valid && held_ok;
        end
    end

    assign ored   = rgb_q[RGB_W-1 -: CHANNEL_W];
    assign ogreen = rgb_q[2*CHANNEL_W-1 -: CHANNEL_W];
    assign oblue  = rgb_q[CHANNEL_W-1:0];

endmodule
